// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking
// single-outstanding-miss refill from instruction memory.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;

  logic             valid_q [SETS];
  logic [TW-1:0]    tag_q   [SETS];
  logic [31:0]      data_q  [SETS];

  logic [IW-1:0]    req_idx, fetch_idx;
  logic [TW-1:0]    req_tag, fetch_tag;
  logic             hit, fill;
  logic [SETS-1:0]  frame_we;

  assign req_idx   = imemaddr[IW+1:2];
  assign req_tag   = imemaddr[31:IW+2];
  assign fetch_idx = fetch_addr_q[IW+1:2];
  assign fetch_tag = fetch_addr_q[31:IW+2];

  assign hit  = (state_q == IDLE) && imemREN && valid_q[req_idx] &&
                (tag_q[req_idx] == req_tag);
  assign fill = (state_q == FETCH) && !iwait;

  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_we
      assign frame_we[gi] = fill && (fetch_idx == IW'(gi));
    end
  endgenerate

  // Reset takes priority over a completing fill, so a refill caught by
  // reset never lands in the array.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < SETS; i++) begin
        if (frame_we[i]) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= fetch_tag;
          data_q[i]  <= iload;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  // The fetch address is frozen for the whole miss; datapath address changes
  // during FETCH are only looked at again once back in IDLE.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    ihit         = 1'b0;
    imemload     = '0;
    iREN         = 1'b0;
    iaddr        = '0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = data_q[req_idx];
        end else if (imemREN) begin
          fetch_addr_d = imemaddr;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = fetch_addr_q;
        if (!iwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, re-hit, conflict eviction,
// address change mid-fetch, reset mid-fetch and idle behaviour.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int total = 0;
  int bad   = 0;

  icache #(.SETS(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs for the cycle are set before the call; outputs are checked mid-cycle,
  // then the bench advances just past the next rising edge.
  task automatic cyc(input string tag, input logic eh, input logic [31:0] el,
                     input logic er, input logic [31:0] ea);
    @(negedge CLK);
    chk({tag, ".ihit"}, {31'd0, ihit}, {31'd0, eh});
    chk({tag, ".imemload"}, imemload, el);
    chk({tag, ".iREN"}, {31'd0, iREN}, {31'd0, er});
    chk({tag, ".iaddr"}, iaddr, ea);
    $display("cycle %s: ihit=%b imemload=%h iREN=%b iaddr=%h", tag, ihit, imemload, iREN, iaddr);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    @(posedge CLK);
    #1;
    cyc("rst_idle", 1'b0, 32'h0, 1'b0, 32'h0);
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    cyc("rst_req", 1'b0, 32'h0, 1'b0, 32'h0);

    // Cold miss with three wait cycles.
    RST   = 1'b0;
    iload = 32'h2008_0001;
    cyc("cold_miss", 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("cold_f1", 1'b0, 32'h0, 1'b1, 32'h40);
    cyc("cold_f2", 1'b0, 32'h0, 1'b1, 32'h40);
    cyc("cold_f3", 1'b0, 32'h0, 1'b1, 32'h40);
    iwait = 1'b0;
    cyc("cold_f4", 1'b0, 32'h0, 1'b1, 32'h40);
    iload = 32'h0;
    cyc("cold_hit", 1'b1, 32'h2008_0001, 1'b0, 32'h0);
    cyc("rehit", 1'b1, 32'h2008_0001, 1'b0, 32'h0);

    // Conflict on index 0 evicts 0x40.
    imemaddr = 32'h80;
    iload    = 32'hAAAA_5555;
    cyc("conf_miss", 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("conf_fetch", 1'b0, 32'h0, 1'b1, 32'h80);
    cyc("conf_hit", 1'b1, 32'hAAAA_5555, 1'b0, 32'h0);
    imemaddr = 32'h40;
    iload    = 32'h2008_0001;
    cyc("evict_miss", 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("evict_fetch", 1'b0, 32'h0, 1'b1, 32'h40);
    cyc("evict_hit", 1'b1, 32'h2008_0001, 1'b0, 32'h0);

    // Address change and request drop during FETCH do not abort the fill.
    imemaddr = 32'h100;
    iwait    = 1'b1;
    iload    = 32'h1111_2222;
    cyc("chg_miss", 1'b0, 32'h0, 1'b0, 32'h0);
    imemaddr = 32'h104;
    cyc("chg_f1", 1'b0, 32'h0, 1'b1, 32'h100);
    imemREN  = 1'b0;
    cyc("chg_f2", 1'b0, 32'h0, 1'b1, 32'h100);
    imemREN  = 1'b1;
    iwait    = 1'b0;
    cyc("chg_f3", 1'b0, 32'h0, 1'b1, 32'h100);
    iload    = 32'h3333_4444;
    cyc("new_miss", 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("new_fetch", 1'b0, 32'h0, 1'b1, 32'h104);
    imemaddr = 32'h100;
    iload    = 32'h0;
    cyc("old_hit", 1'b1, 32'h1111_2222, 1'b0, 32'h0);
    imemaddr = 32'h104;
    cyc("new_hit", 1'b1, 32'h3333_4444, 1'b0, 32'h0);
    imemaddr = 32'h40;
    cyc("evicted_by_100", 1'b0, 32'h0, 1'b0, 32'h0);
    iload    = 32'h2008_0001;
    cyc("refill40", 1'b0, 32'h0, 1'b1, 32'h40);

    // Reset mid-fetch drops the fill and clears all frames.
    imemaddr = 32'h200;
    iwait    = 1'b1;
    cyc("rf_miss", 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("rf_f1", 1'b0, 32'h0, 1'b1, 32'h200);
    RST   = 1'b1;
    iwait = 1'b0;
    iload = 32'hDEAD_BEEF;
    cyc("rf_f2_rst", 1'b0, 32'h0, 1'b1, 32'h200);
    RST     = 1'b0;
    imemREN = 1'b0;
    cyc("rf_after", 1'b0, 32'h0, 1'b0, 32'h0);
    imemREN  = 1'b1;
    imemaddr = 32'h104;
    cyc("rf_104_miss", 1'b0, 32'h0, 1'b0, 32'h0);
    iload    = 32'h5555_6666;
    cyc("rf_104_fetch", 1'b0, 32'h0, 1'b1, 32'h104);
    imemaddr = 32'h200;
    cyc("rf_200_miss", 1'b0, 32'h0, 1'b0, 32'h0);
    iload    = 32'h7777_8888;
    cyc("rf_200_fetch", 1'b0, 32'h0, 1'b1, 32'h200);
    iload    = 32'h0;
    cyc("rf_200_hit", 1'b1, 32'h7777_8888, 1'b0, 32'h0);

    // No request: nothing happens even with the address on a valid frame.
    imemREN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      iwait = i[0];
      cyc($sformatf("noreq%0d", i), 1'b0, 32'h0, 1'b0, 32'h0);
    end
    imemREN = 1'b1;
    cyc("noreq_then_hit", 1'b1, 32'h7777_8888, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
